cordic_divide: RTL and testbench



---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_linear_stage.sv | 56 +++++
 rtl/cordic_divide.sv | 137 +++++++++++++
 tb/tb_cordic_divide.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared Q1.14 constants, FSM state encoding, stage mode bits
//                and the WL-bit saturation helper for the linear CORDIC
//                multiplier/divider family.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Q1.14 number format
    localparam int             WL      = 16;
    localparam int             FL      = 14;
    localparam logic [WL-1:0]  ONE     = 16'h4000;
    localparam logic [WL-1:0]  SAT_MAX = 16'h7FFF;
    localparam logic [WL-1:0]  SAT_MIN = 16'h8000;

    // Sequencer states
    localparam logic [1:0]     IDLE    = 2'd0;
    localparam logic [1:0]     CALC    = 2'd1;
    localparam logic [1:0]     DONE    = 2'd2;

    // Linear stage direction policy
    localparam logic           MODE_ROT = 1'b0;  // drive z toward zero (multiply)
    localparam logic           MODE_VEC = 1'b1;  // drive y toward zero (divide)

    // Clamp a WL+1-bit signed value into WL bits: overflow shows up as the
    // top two bits disagreeing.
    function automatic logic [WL-1:0] sat_wl(input logic signed [WL:0] v);
        logic [WL-1:0] r;
        if (v[WL] != v[WL-1]) begin
            r = v[WL] ? SAT_MIN : SAT_MAX;
        end else begin
            r = v[WL-1:0];
        end
        return r;
    endfunction

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_linear_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_linear_stage
//  Description : One combinational linear-mode CORDIC iteration. Vectoring
//                mode steers y toward zero (division); rotation mode steers
//                z toward zero (multiplication).
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_linear_stage #(
    parameter int WL = 16,
    parameter int FL = 14,
    parameter int IW = 4
) (
    input  logic signed [WL+1:0] i_x,
    input  logic signed [WL+1:0] i_y,
    input  logic signed [WL:0]   i_z,
    input  logic        [IW-1:0] i_iter,
    input  logic                 i_mode,
    output logic signed [WL+1:0] o_y,
    output logic signed [WL:0]   o_z
);
    import cordic_pkg::*;

    localparam logic signed [WL:0] c_one = (WL+1)'(1) << FL;

    logic signed [WL+1:0] w_x_sh;
    logic signed [WL:0]   w_one_sh;
    logic                 w_sub;

    // Shifted operands and the direction decision for this iteration
    always_comb begin
        w_x_sh   = i_x >>> i_iter;
        w_one_sh = c_one >>> i_iter;
        // y == 0 has a clear sign bit and therefore counts as non-negative
        if (i_mode == MODE_VEC) begin
            w_sub = (i_y[WL+1] == i_x[WL+1]);
        end else begin
            w_sub = i_z[WL];
        end
    end

    // Apply the micro-step in the chosen direction
    always_comb begin
        o_y = i_y;
        o_z = i_z;
        if (w_sub) begin
            o_y = i_y - w_x_sh;
            o_z = i_z + w_one_sh;
        end else begin
            o_y = i_y + w_x_sh;
            o_z = i_z - w_one_sh;
        end
    end

endmodule : cordic_linear_stage
`default_nettype wire

// File: rtl/cordic_divide.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_divide
//  Description : Q1.14 divider, quot = num / den, using iterative linear
//                vectoring CORDIC (shift/add only). Flags divide-by-zero and
//                |quotient| >= 2 and returns a saturated result for either.
//                Constant latency of N_ITER+1 cycles from accept to done.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_divide #(
    parameter int WL     = 16,
    parameter int FL     = 14,
    parameter int N_ITER = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [WL-1:0] num,
    input  logic signed [WL-1:0] den,
    output logic signed [WL-1:0] quot,
    output logic                 done,
    output logic                 busy,
    output logic                 dz,
    output logic                 ovf
);
    import cordic_pkg::*;

    localparam int           IW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [IW-1:0] c_last = IW'(N_ITER - 1);

    logic [1:0]           r_state;
    logic [IW-1:0]        r_iter;
    logic signed [WL+1:0] r_x;
    logic signed [WL+1:0] r_y;
    logic signed [WL:0]   r_z;
    logic                 r_dz;
    logic                 r_ovf;
    logic                 r_neg;

    logic signed [WL+1:0] w_num_ext;
    logic signed [WL+1:0] w_den_ext;
    logic        [WL+1:0] w_abs_num;
    logic        [WL+1:0] w_abs_den;
    logic                 w_dz;
    logic                 w_ovf;
    logic signed [WL+1:0] w_y_next;
    logic signed [WL:0]   w_z_next;

    // Operand extension and range/zero checks evaluated at accept time;
    // WL+2 bits hold both |-2.0| and 2*|den| without wrapping
    always_comb begin
        w_num_ext = {{2{num[WL-1]}}, num};
        w_den_ext = {{2{den[WL-1]}}, den};
        w_abs_num = w_num_ext[WL+1] ? (~w_num_ext + 1'b1) : w_num_ext;
        w_abs_den = w_den_ext[WL+1] ? (~w_den_ext + 1'b1) : w_den_ext;
        w_dz      = (den == '0);
        w_ovf     = !w_dz && (w_abs_num >= (w_abs_den << 1));
    end

    cordic_linear_stage #(
        .WL (WL),
        .FL (FL),
        .IW (IW)
    ) u_stage (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_iter (r_iter),
        .i_mode (MODE_VEC),
        .o_y    (w_y_next),
        .o_z    (w_z_next)
    );

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
            quot    <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_x     <= w_den_ext;
                        r_y     <= w_num_ext;
                        r_z     <= '0;
                        r_iter  <= '0;
                        r_dz    <= w_dz;
                        r_ovf   <= w_ovf;
                        // num = 0 and den = 0 both count as positive here
                        r_neg   <= num[WL-1] ^ den[WL-1];
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    // Iterations run even for flagged operands so latency
                    // never depends on the data
                    r_y    <= w_y_next;
                    r_z    <= w_z_next;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == c_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (r_dz || r_ovf) begin
                        quot <= r_neg ? SAT_MIN : SAT_MAX;
                    end else begin
                        quot <= sat_wl(r_z);
                    end
                    dz      <= r_dz;
                    ovf     <= r_ovf;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : cordic_divide
`default_nettype wire

// File: tb/tb_cordic_divide.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_divide
//  Description : Directed self-checking bench for cordic_divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_divide;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] num;
    logic signed [15:0] den;
    logic signed [15:0] quot;
    logic               done;
    logic               busy;
    logic               dz;
    logic               ovf;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_divide #(
        .WL     (16),
        .FL     (14),
        .N_ITER (15)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .num   (num),
        .den   (den),
        .quot  (quot),
        .done  (done),
        .busy  (busy),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Quotient checked against a tolerance: a value inside the band is
    // reported as the expected value, anything else as itself
    task automatic check_quot(input string tag, input logic [15:0] q, input logic [15:0] exp_q, input int tol);
        int diff;
        diff = int'($signed(q)) - int'($signed(exp_q));
        if (diff < 0) diff = -diff;
        check_val(tag, (diff <= tol) ? {16'h0, exp_q} : {16'h0, q}, {16'h0, exp_q});
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_q, input int tol,
                          input logic exp_dz, input logic exp_ovf);
        int  cyc;
        logic seen;
        @(negedge clk);
        num   = a;
        den   = b;
        start = 1'b1;
        @(posedge clk); #1;
        check_val({tag, "_busy"}, {31'h0, busy}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) cyc = 99;
        check_val({tag, "_lat"}, cyc, 16);
        check_quot({tag, "_quot"}, quot, exp_q, tol);
        check_val({tag, "_dz"},  {31'h0, dz},  {31'h0, exp_dz});
        check_val({tag, "_ovf"}, {31'h0, ovf}, {31'h0, exp_ovf});
        @(posedge clk); #1;
        check_val({tag, "_done_fall"}, {31'h0, done}, 32'h0);
        check_val({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int          n_done;
        logic [15:0] q_seen;
        logic        dz_seen;
        logic        ovf_seen;

        rst   = 1'b1;
        start = 1'b0;
        num   = '0;
        den   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_quot", {16'h0, quot}, 32'h0);
        check_val("rst_done", {31'h0, done}, 32'h0);
        check_val("rst_busy", {31'h0, busy}, 32'h0);
        check_val("rst_dz",   {31'h0, dz},   32'h0);
        check_val("rst_ovf",  {31'h0, ovf},  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Ordinary quotients
        run_op("half",     16'h2000, 16'h4000, 16'h2000, 2, 1'b0, 1'b0);
        run_op("neg1p5",   16'hD000, 16'h2000, 16'hA000, 2, 1'b0, 1'b0);
        run_op("negneg",   16'hE000, 16'hC000, 16'h2000, 2, 1'b0, 1'b0);
        // Divide by zero, sign of numerator selects the rail
        run_op("dz_pos",   16'h4000, 16'h0000, 16'h7FFF, 0, 1'b1, 1'b0);
        run_op("dz_neg",   16'hC000, 16'h0000, 16'h8000, 0, 1'b1, 1'b0);
        // Range overflow: |num| >= 2|den|, including the equality boundary
        run_op("ovf_pos",  16'h6000, 16'h2000, 16'h7FFF, 0, 1'b0, 1'b1);
        run_op("ovf_edge", 16'h4000, 16'h2000, 16'h7FFF, 0, 1'b0, 1'b1);
        run_op("ovf_neg",  16'h6000, 16'hE000, 16'h8000, 0, 1'b0, 1'b1);

        // Reset during CALC: outputs hold the saturated result and ovf before
        @(negedge clk);
        num   = 16'h1000;
        den   = 16'h4000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_quot", {16'h0, quot}, 32'h0);
        check_val("midrst_done", {31'h0, done}, 32'h0);
        check_val("midrst_busy", {31'h0, busy}, 32'h0);
        check_val("midrst_ovf",  {31'h0, ovf},  32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 16'h1000, 16'h4000, 16'h1000, 2, 1'b0, 1'b0);

        // Starts during a busy operation are ignored
        @(negedge clk);
        num   = 16'h2000;
        den   = 16'h4000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        n_done   = 0;
        q_seen   = 16'h0;
        dz_seen  = 1'b0;
        ovf_seen = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (c == 3 || c == 10) begin
                start = 1'b1;
                num   = 16'h6000;
                den   = 16'h2000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                q_seen   = quot;
                dz_seen  = dz;
                ovf_seen = ovf;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("ign_ndone", n_done, 1);
        check_quot("ign_quot", q_seen, 16'h2000, 2);
        check_val("ign_dz",  {31'h0, dz_seen},  32'h0);
        check_val("ign_ovf", {31'h0, ovf_seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cordic_divide
`default_nettype wire
